cache_fill_fsm: RTL and testbench

Miss-handling controller that sits between the pipeline's instruction/data cache and the shared multi-cycle main memory. On a cache miss it stalls the pipeline and fetches the full cache block from memory as a stream of pipelined word reads. It steers each returned word into the cache data array, then writes the tag and releases the stall. One instance serves the IF-stage instruction cache and one serves the MEM-stage data cache.

---
 rtl/cache_fill_fsm.sv | 118 +++++++++++
 tb/tb_cache_fill_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache miss fill controller. It fetches one block as pipelined
//               word reads, writes each returned word, then writes the tag.
//               Optional macro CACHE_FILL_CRITICAL_WORD_EN: requests the missed
//               word first, then the rest of the block with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
  parameter int WORDS      = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_WIDTH-1:0]    miss_address,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     mem_read_en,
  output logic [ADDR_WIDTH-1:0]    memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     write_tag_array
);

  localparam int c_IDX_W = $clog2(WORDS);
  localparam int c_CNT_W = c_IDX_W + 1;
  localparam int c_OFF_W = c_IDX_W + 1;
  localparam int c_HI_W  = ADDR_WIDTH - c_OFF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_TAG  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_HI_W-1:0]    r_base_hi;
  logic [c_CNT_W-1:0]   r_issue_cnt;
  logic [c_CNT_W-1:0]   r_rcv_cnt;
  logic [c_IDX_W-1:0]   w_start;
  logic [c_IDX_W-1:0]   w_issue_off;
  logic [c_IDX_W-1:0]   w_rcv_off;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_EN
  logic [c_IDX_W-1:0]   r_start;
  assign w_start = r_start;
`else
  assign w_start = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base_hi   <= '0;
      r_issue_cnt <= '0;
      r_rcv_cnt   <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_EN
      r_start     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_base_hi   <= miss_address[ADDR_WIDTH-1:c_OFF_W];
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_EN
            r_start     <= miss_address[c_OFF_W-1:1];
`endif
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          // WORDS is a power of two, so the counter MSB marks "all issued".
          if (!r_issue_cnt[c_IDX_W]) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (memory_data_valid) begin
            r_rcv_cnt <= r_rcv_cnt + 1'b1;
            if (r_rcv_cnt == c_CNT_W'(WORDS - 1)) begin
              r_state <= S_TAG;
            end
          end
        end
        S_TAG: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Offsets are c_IDX_W bits wide, so the sum wraps within the block.
  assign w_issue_off = w_start + r_issue_cnt[c_IDX_W-1:0];
  assign w_rcv_off   = w_start + r_rcv_cnt[c_IDX_W-1:0];
  assign w_rd        = (r_state == S_FILL) && !r_issue_cnt[c_IDX_W];
  assign w_wr        = (r_state == S_FILL) && memory_data_valid;

  assign fsm_busy         = (r_state == S_FILL) || (r_state == S_TAG);
  assign mem_read_en      = w_rd;
  assign memory_address   = w_rd ? {r_base_hi, w_issue_off, 1'b0} : '0;
  assign write_data_array = w_wr;
  assign fill_word        = w_wr ? w_rcv_off : '0;
  assign write_tag_array  = (r_state == S_TAG);

  assign w_unused_addr_bits = ^miss_address[c_OFF_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Self-checking bench for cache_fill_fsm with a queue-based
//               reference model and a latency-driven memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_fill_fsm;

  localparam int W  = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          memory_data_valid;
  logic          fsm_busy;
  logic          mem_read_en;
  logic [AW-1:0] memory_address;
  logic          write_data_array;
  logic [2:0]    fill_word;
  logic          write_tag_array;

  cache_fill_fsm #(.WORDS(W), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word         (fill_word),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_phase = 0;        // 0 idle, 1 filling, 2 tag
  logic [AW-1:0] q_req[$];           // addresses still to be requested
  int            q_word[$];          // word indices still to be written
  int            q_ready[$];         // cycle at which each outstanding response may return
  int            g_vsched[$];        // explicit valid cycles (relative), overrides latency model
  int            g_now = 0;
  int            g_rel = 0;
  int            g_lat = 4;
  bit            g_jitter = 0;
  bit            g_spur = 0;
  int            g_busy_cnt, g_tag_rel, g_wr_cnt, g_first_rel;
  logic [AW-1:0] g_first_req;
  bit            g_seen_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(fsm_busy), 0);
    chk({pfx, "_rd"},   32'(mem_read_en), 0);
    chk({pfx, "_addr"}, 32'(memory_address), 0);
    chk({pfx, "_wr"},   32'(write_data_array), 0);
    chk({pfx, "_fw"},   32'(fill_word), 0);
    chk({pfx, "_tag"},  32'(write_tag_array), 0);
  endtask

  task automatic model_clear();
    q_req.delete(); q_word.delete(); q_ready.delete();
    m_phase = 0; g_rel = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance DUT and model.
  task automatic cycle(input logic miss, input logic [AW-1:0] addr);
    logic          v, e_rd, e_wr;
    logic [AW-1:0] e_addr, base;
    int            e_fw, st;
    miss_detected = miss;
    miss_address  = addr;
    v = 1'b0;
    if (m_phase == 1) begin
      if (g_vsched.size() > 0) begin
        foreach (g_vsched[i]) if (g_vsched[i] == g_rel) v = 1'b1;
      end else if (q_ready.size() > 0 && q_ready[0] <= g_now) begin
        v = g_jitter ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end else if (g_spur) begin
      v = ($urandom_range(0, 2) == 0);
    end
    memory_data_valid = v;
    e_rd   = (m_phase == 1) && (q_req.size() > 0);
    e_addr = e_rd ? q_req[0] : '0;
    e_wr   = (m_phase == 1) && v;
    e_fw   = e_wr ? q_word[0] : 0;
    #1;
    chk("fsm_busy",         32'(fsm_busy),         32'(m_phase != 0));
    chk("mem_read_en",      32'(mem_read_en),      32'(e_rd));
    chk("memory_address",   32'(memory_address),   32'(e_addr));
    chk("write_data_array", 32'(write_data_array), 32'(e_wr));
    chk("fill_word",        32'(fill_word),        32'(e_fw));
    chk("write_tag_array",  32'(write_tag_array),  32'(m_phase == 2));
    if (fsm_busy) g_busy_cnt++;
    if (write_tag_array) g_tag_rel = g_rel;
    if (write_data_array) g_wr_cnt++;
    if (mem_read_en && !g_seen_req) begin
      g_first_req = memory_address; g_first_rel = g_rel; g_seen_req = 1;
    end
    @(posedge clk); #1;
    case (m_phase)
      0: begin
        if (miss) begin
          base = addr & ~AW'(2 * W - 1);
`ifdef CACHE_FILL_CRITICAL_WORD_EN
          st = int'(addr >> 1) % W;
`else
          st = 0;
`endif
          q_req.delete(); q_word.delete(); q_ready.delete();
          for (int k = 0; k < W; k++) begin
            q_req.push_back(base + AW'(2 * ((st + k) % W)));
            q_word.push_back((st + k) % W);
          end
          m_phase = 1;
          g_rel = 0;
        end
      end
      1: begin
        if (e_rd) begin
          void'(q_req.pop_front());
          q_ready.push_back(g_now + g_lat);
        end
        if (e_wr) begin
          void'(q_word.pop_front());
          if (q_ready.size() > 0) void'(q_ready.pop_front());
        end
        if (q_word.size() == 0) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    g_rel++;
    g_now++;
  endtask

  // Miss in the current idle cycle, then run until the model is idle again.
  task automatic fill(input logic [AW-1:0] addr, input int noise);
    int guard;
    guard = 0;
    g_seen_req = 0; g_wr_cnt = 0; g_busy_cnt = 0; g_tag_rel = -1; g_first_rel = -1;
    cycle(1'b1, addr);
    while (m_phase != 0 && guard < 200) begin
      guard++;
      case (noise)
        1:       cycle(g_rel == 3, (g_rel == 3) ? 16'h4000 : addr);
        2:       cycle(1'($urandom_range(0, 1)), 16'($urandom));
        default: cycle(1'b1, addr);
      endcase
    end
  endtask

  initial begin
    logic [AW-1:0] exp_first;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

`ifdef CACHE_FILL_CRITICAL_WORD_EN
    exp_first = 16'h1234;
`else
    exp_first = 16'h1230;
`endif

    // Basic fill with fixed latency 4.
    g_lat = 4; g_jitter = 0; g_spur = 0;
    fill(16'h1234, 0);
    chk("t1_first_req", 32'(g_first_req), 32'(exp_first));
    chk("t1_busy_cycles", g_busy_cnt, 13);
    chk("t1_tag_cycle", g_tag_rel, 13);
    chk("t1_writes", g_wr_cnt, 8);
    cycle(1'b0, 16'h0);

    // Spurious valids in idle/tag, stray miss pulse at 0x4000 mid-fill.
    g_spur = 1;
    repeat (4) cycle(1'b0, 16'($urandom));
    fill(16'h1234, 1);
    chk("t3_first_req", 32'(g_first_req), 32'(exp_first));
    chk("t3_writes", g_wr_cnt, 8);
    g_spur = 0;
    cycle(1'b0, 16'h0);

    // Irregular response timing.
    g_vsched = '{5, 7, 8, 11, 12, 13, 14, 20};
    fill(16'h1234, 0);
    chk("t4_tag_cycle", g_tag_rel, 21);
    chk("t4_writes", g_wr_cnt, 8);
    g_vsched.delete();
    cycle(1'b0, 16'h0);

    // Asynchronous reset in cycle 6 of a fill.
    cycle(1'b1, 16'h1234);
    repeat (5) cycle(1'b1, 16'h1234);
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    g_now++;
    cycle(1'b0, 16'h0);
    fill(16'h0010, 0);
    chk("t5_first_req", 32'(g_first_req), 32'h0010);
    chk("t5_first_rel", g_first_rel, 1);
    chk("t5_writes", g_wr_cnt, 8);

    // Back-to-back fills: second miss sampled at the first idle edge.
    cycle(1'b0, 16'h0);
    fill(16'h0000, 0);
    chk("t6a_tag_cycle", g_tag_rel, 13);
    fill(16'h0020, 0);
    chk("t6b_first_req", 32'(g_first_req), 32'h0020);
    chk("t6b_first_rel", g_first_rel, 1);
    chk("t6b_writes", g_wr_cnt, 8);

    // Randomized fills against the model.
    for (int n = 0; n < 25; n++) begin
      g_lat    = $urandom_range(1, 6);
      g_jitter = 1'($urandom_range(0, 1));
      g_spur   = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) cycle(1'b0, 16'($urandom));
      fill(16'($urandom), $urandom_range(0, 1) * 2);
      chk("rand_writes", g_wr_cnt, 8);
    end
    g_spur = 0;
    cycle(1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
